// File: rtl/stream_frame_tx_if.sv
// rtl/stream_frame_tx_if.sv - valid-ready beat stream between frame source and FIFO writer
interface stream_frame_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;

    modport master (output o_valid, output o_data, input i_ready);
    modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/stream_frame_tx.sv
// rtl/stream_frame_tx.sv - frame source: header, seed+index payload, optional XOR trailer (STREAM_TX_CHECKSUM_EN)
module stream_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [DATA_WIDTH-1:0] i_seed,
    output logic                  o_busy,
    output logic                  o_done,
    stream_frame_tx_if.master     tx
);

`ifdef STREAM_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;
`ifdef STREAM_TX_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
`endif

    logic                  hs;

    assign hs         = valid_q & tx.i_ready;
    assign tx.o_valid = valid_q;
    assign tx.o_data  = data_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

    // Frame sequencer; every output is a register so i_ready never reaches o_valid/o_data combinationally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            seed_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef STREAM_TX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A zero-length request would produce a header with no payload, so it is dropped.
                    if (i_start && (i_len != '0)) begin
                        len_q   <= i_len;
                        seed_q  <= i_seed;
                        idx_q   <= '0;
                        state   <= HDR;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        data_q  <= DATA_WIDTH'(i_len);
`ifdef STREAM_TX_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                HDR: begin
                    if (hs) begin
`ifdef STREAM_TX_CHECKSUM_EN
                        csum_q <= csum_q ^ data_q;
`endif
                        data_q <= seed_q;
                        idx_q  <= '0;
                        state  <= PAY;
                    end
                end
                PAY: begin
                    if (hs) begin
                        if ((idx_q + LEN_ONE) == len_q) begin
`ifdef STREAM_TX_CHECKSUM_EN
                            // Trailer carries the running XOR including this last payload beat.
                            csum_q <= csum_q ^ data_q;
                            data_q <= csum_q ^ data_q;
                            state  <= CHK;
`else
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            data_q  <= '0;
                            state   <= IDLE;
`endif
                        end else begin
`ifdef STREAM_TX_CHECKSUM_EN
                            csum_q <= csum_q ^ data_q;
`endif
                            idx_q  <= idx_q + LEN_ONE;
                            data_q <= data_q + DATA_ONE;
                        end
                    end
                end
`ifdef STREAM_TX_CHECKSUM_EN
                CHK: begin
                    if (hs) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        data_q  <= '0;
                        state   <= IDLE;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
